// File: rtl/pd_pkg.sv
// Shared constants and types for the PD block sequencer.
// SHA-256 padding geometry and the sequencer state encoding.
package pd_pkg;

    localparam int SHA_BLK_BITS = 512;
    localparam int SHA_BLK_BYTES = SHA_BLK_BITS / 8;
    localparam logic [7:0] SHA_PAD_BYTE = 8'h80;
    localparam int SHA_LEN_BITS = 64;
    localparam int SHA_LEN_BYTES = SHA_LEN_BITS / 8;

    typedef enum logic [0:0] {
        IDLE,
        EMIT
    } pd_seq_state_t;

    // Number of padded blocks needed for a message of len bytes.
    function automatic int calc_nblk(input int len);
        return (len + SHA_LEN_BYTES) / SHA_BLK_BYTES + 1;
    endfunction

endpackage

// File: rtl/pd_pad_block.sv
// Combinational SHA-256 padder: builds block idx of the padded stream
// from a latched message, its length and the total block count.
module pd_pad_block
    import pd_pkg::*;
#(
    parameter int MAX_BYTES = 80,
    parameter int LEN_W = 16,
    parameter int IDX_W = 1,
    parameter int NB_W = 2
) (
    input  logic [MAX_BYTES*8-1:0]  msg_i,
    input  logic [LEN_W-1:0]        len_i,
    input  logic [NB_W-1:0]         nblk_i,
    input  logic [IDX_W-1:0]        idx_i,
    output logic [SHA_BLK_BITS-1:0] blk_o
);

    localparam int TAIL = SHA_BLK_BYTES - SHA_LEN_BYTES;

    logic [SHA_LEN_BITS-1:0] lenbits;
    logic                    last_blk;
    logic [7:0]              b;
    int                      k;

    // Select message byte, pad marker, length field or zero per byte.
    always_comb begin
        blk_o = '0;
        k = 0;
        b = 8'h00;
        lenbits = SHA_LEN_BITS'(len_i) << 3;
        last_blk = (NB_W'(idx_i) + NB_W'(1)) == nblk_i;
        for (int j = 0; j < SHA_BLK_BYTES; j++) begin
            k = int'(idx_i) * SHA_BLK_BYTES + j;
            b = 8'h00;
            if (k < int'(len_i)) begin
                if (k < MAX_BYTES) begin
                    b = msg_i[(MAX_BYTES-1-k)*8 +: 8];
                end
            end else if (k == int'(len_i)) begin
                b = SHA_PAD_BYTE;
            end else if (last_blk && j >= TAIL) begin
                b = lenbits[(7 - (j % 8))*8 +: 8];
            end
            blk_o[(SHA_BLK_BYTES-1-j)*8 +: 8] = b;
        end
    end

endmodule

// File: rtl/pd_block_sequencer.sv
// Message-to-block sequencer: latches one message and streams its
// SHA-256 padded 512-bit blocks over a valid/ready handshake.
module pd_block_sequencer
    import pd_pkg::*;
#(
    parameter int MAX_BYTES = 80,
    parameter int LEN_W = 16,
    localparam int NBLK = calc_nblk(MAX_BYTES),
    localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    msg_valid,
    output logic                    msg_ready,
    input  logic [MAX_BYTES*8-1:0]  msg_data,
    input  logic [LEN_W-1:0]        msg_len,
    input  logic                    flip_en,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [SHA_BLK_BITS-1:0] blk_data,
    output logic                    blk_first,
    output logic                    blk_last,
    output logic [IDX_W-1:0]        blk_idx,
    output logic                    err
);

    localparam int NB_W = $clog2(NBLK + 1);

    pd_seq_state_t           state_q;
    logic [MAX_BYTES*8-1:0]  msg_q;
    logic [LEN_W-1:0]        len_q;
    logic [NB_W-1:0]         nblk_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    valid_q;
    logic [SHA_BLK_BITS-1:0] data_q;
    logic                    first_q;
    logic                    last_q;
    logic                    err_q;

    logic [MAX_BYTES*8-1:0]  msg_flip;
    logic [NB_W-1:0]         nblk_in;
    logic                    len_ok;
    logic [MAX_BYTES*8-1:0]  pad_msg;
    logic [LEN_W-1:0]        pad_len;
    logic [NB_W-1:0]         pad_nblk;
    logic [IDX_W-1:0]        pad_idx_d;
    logic                    pad_last_d;
    logic [SHA_BLK_BITS-1:0] pad_blk_d;

    // Optional byte reversal of every aligned 32-bit message word.
    always_comb begin
        msg_flip = msg_data;
        if (flip_en) begin
            for (int w = 0; w < MAX_BYTES / 4; w++) begin
                msg_flip[w*32 +: 32] = {msg_data[w*32 +: 8],
                                        msg_data[w*32+8 +: 8],
                                        msg_data[w*32+16 +: 8],
                                        msg_data[w*32+24 +: 8]};
            end
        end
    end

    assign nblk_in = NB_W'(calc_nblk(int'(msg_len)));
    assign len_ok  = int'(msg_len) <= MAX_BYTES;

    // Padder sees the incoming message in IDLE, the next block in EMIT.
    always_comb begin
        if (state_q == IDLE) begin
            pad_msg   = msg_flip;
            pad_len   = msg_len;
            pad_nblk  = nblk_in;
            pad_idx_d = '0;
        end else begin
            pad_msg   = msg_q;
            pad_len   = len_q;
            pad_nblk  = nblk_q;
            pad_idx_d = idx_q + IDX_W'(1);
        end
        pad_last_d = (NB_W'(pad_idx_d) + NB_W'(1)) == pad_nblk;
    end

    pd_pad_block #(
        .MAX_BYTES(MAX_BYTES),
        .LEN_W    (LEN_W),
        .IDX_W    (IDX_W),
        .NB_W     (NB_W)
    ) u_pad (
        .msg_i (pad_msg),
        .len_i (pad_len),
        .nblk_i(pad_nblk),
        .idx_i (pad_idx_d),
        .blk_o (pad_blk_d)
    );

    // Sequencer FSM with registered block outputs and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            msg_q   <= '0;
            len_q   <= '0;
            nblk_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (msg_valid && len_ok) begin
                        msg_q   <= msg_flip;
                        len_q   <= msg_len;
                        nblk_q  <= nblk_in;
                        idx_q   <= '0;
                        data_q  <= pad_blk_d;
                        first_q <= 1'b1;
                        last_q  <= pad_last_d;
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end else if (msg_valid) begin
                        err_q <= 1'b1;
                    end
                end
                EMIT: begin
                    if (blk_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= pad_idx_d;
                            data_q  <= pad_blk_d;
                            first_q <= 1'b0;
                            last_q  <= pad_last_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign msg_ready = (state_q == IDLE);
    assign blk_valid = valid_q;
    assign blk_data  = data_q;
    assign blk_first = first_q;
    assign blk_last  = last_q;
    assign blk_idx   = idx_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pd_block_sequencer.sv
// Directed bench for pd_block_sequencer with hand-computed blocks.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pd_block_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         msg_valid;
    logic         msg_ready;
    logic [639:0] msg_data;
    logic [15:0]  msg_len;
    logic         flip_en;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic [0:0]   blk_idx;
    logic         err;

    int checks = 0;
    int failures = 0;

    logic [511:0] hdr0;
    logic [127:0] hdr1;
    logic [447:0] p56;

    pd_block_sequencer #(.MAX_BYTES(80), .LEN_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .msg_valid(msg_valid),
        .msg_ready(msg_ready),
        .msg_data (msg_data),
        .msg_len  (msg_len),
        .flip_en  (flip_en),
        .blk_valid(blk_valid),
        .blk_ready(blk_ready),
        .blk_data (blk_data),
        .blk_first(blk_first),
        .blk_last (blk_last),
        .blk_idx  (blk_idx),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [639:0] d, input logic [15:0] l,
                        input logic f);
        msg_data  = d;
        msg_len   = l;
        flip_en   = f;
        msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
    endtask

    task automatic chk_meta(input string tag, input logic fi,
                            input logic la, input logic id);
        chk({tag, "_valid"}, 512'(blk_valid), 512'(1));
        chk({tag, "_first"}, 512'(blk_first), 512'(fi));
        chk({tag, "_last"}, 512'(blk_last), 512'(la));
        chk({tag, "_idx"}, 512'(blk_idx), 512'(id));
    endtask

    initial begin
        hdr0 = {32'h01000000, 32'h50120119, 32'h172a3b4c,
                32'h5d6e7f80, 32'h91a2b3c4, 32'hd5e6f708,
                32'h192a3b4c, 32'h5d6e7f81, 32'h92a3b4c5,
                32'hd6e7f809, 32'h1a2b3c4d, 32'h5e6f7082,
                32'h93a4b5c6, 32'hd7e8f90a, 32'h1b2c3d4e,
                32'hefb5a4ac};
        hdr1 = 128'h4247e9f3_37221b4d_4c86041b_0f2b5710;
        p56 = 448'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f3031323334353637;

        rst = 1'b1;
        msg_valid = 1'b0;
        msg_data = '0;
        msg_len = '0;
        flip_en = 1'b0;
        blk_ready = 1'b0;
        tick();
        chk("rst_valid", 512'(blk_valid), 512'(0));
        chk("rst_ready", 512'(msg_ready), 512'(1));
        chk("rst_data", blk_data, 512'h0);
        chk("rst_first", 512'(blk_first), 512'(0));
        chk("rst_last", 512'(blk_last), 512'(0));
        chk("rst_idx", 512'(blk_idx), 512'(0));
        chk("rst_err", 512'(err), 512'(0));
        rst = 1'b0;
        tick();

        // 1: 80-byte header, two blocks
        send({hdr0, hdr1}, 16'd80, 1'b0);
        chk("hdr_b0", blk_data, hdr0);
        chk_meta("hdr_b0", 1'b1, 1'b0, 1'b0);
        chk("hdr_busy", 512'(msg_ready), 512'(0));
        blk_ready = 1'b1;
        tick();
        chk("hdr_b1", blk_data, {hdr1, 8'h80, 312'h0, 64'h280});
        chk_meta("hdr_b1", 1'b0, 1'b1, 1'b1);
        tick();
        chk("hdr_done_valid", 512'(blk_valid), 512'(0));
        chk("hdr_done_ready", 512'(msg_ready), 512'(1));
        blk_ready = 1'b0;

        // 2: empty message
        send({hdr0, hdr1}, 16'd0, 1'b0);
        chk("len0_b0", blk_data, {8'h80, 440'h0, 64'h0});
        chk_meta("len0_b0", 1'b1, 1'b1, 1'b0);
        blk_ready = 1'b1;
        tick();
        chk("len0_done", 512'(blk_valid), 512'(0));
        blk_ready = 1'b0;
        tick();

        // len=55: still a single block
        send({p56, {24{8'haa}}}, 16'd55, 1'b0);
        chk("len55_b0", blk_data, {p56[447:8], 8'h80, 64'h1b8});
        chk_meta("len55_b0", 1'b1, 1'b1, 1'b0);
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        tick();

        // 3: len=56 spills the length into a second block
        send({p56, {24{8'haa}}}, 16'd56, 1'b0);
        chk("len56_b0", blk_data, {p56, 8'h80, 56'h0});
        chk_meta("len56_b0", 1'b1, 1'b0, 1'b0);
        blk_ready = 1'b1;
        tick();
        chk("len56_b1", blk_data, {448'h0, 64'h1c0});
        chk_meta("len56_b1", 1'b0, 1'b1, 1'b1);
        tick();
        blk_ready = 1'b0;
        tick();

        // len=64: pad marker opens block 1
        send({hdr0, hdr1}, 16'd64, 1'b0);
        chk("len64_b0", blk_data, hdr0);
        blk_ready = 1'b1;
        tick();
        chk("len64_b1", blk_data, {8'h80, 440'h0, 64'h200});
        chk_meta("len64_b1", 1'b0, 1'b1, 1'b1);
        tick();
        blk_ready = 1'b0;
        tick();

        // 4: word flip, trailing flipped bytes ignored
        send({32'h01000000, {76{8'h55}}}, 16'd4, 1'b1);
        chk("flip_b0", blk_data, {32'h00000001, 8'h80, 408'h0, 64'h20});
        chk_meta("flip_b0", 1'b1, 1'b1, 1'b0);
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        tick();

        // 5: backpressure; a new msg_valid while busy is ignored
        send({hdr0, hdr1}, 16'd80, 1'b0);
        msg_data = {p56, {24{8'haa}}};
        msg_len = 16'd0;
        msg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_data", blk_data, hdr0);
            chk("bp_idx", 512'(blk_idx), 512'(0));
            chk("bp_busy", 512'(msg_ready), 512'(0));
        end
        msg_valid = 1'b0;
        blk_ready = 1'b1;
        tick();
        chk("bp_b1", blk_data, {hdr1, 8'h80, 312'h0, 64'h280});
        chk_meta("bp_b1", 1'b0, 1'b1, 1'b1);
        tick();
        chk("bp_done", 512'(blk_valid), 512'(0));
        blk_ready = 1'b0;
        tick();

        // 6: reset after the block 0 handshake drops the message
        send({p56, {24{8'haa}}}, 16'd56, 1'b0);
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 512'(blk_valid), 512'(0));
        chk("mid_rst_ready", 512'(msg_ready), 512'(1));
        tick();
        rst = 1'b0;
        blk_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", 512'(blk_valid), 512'(0));
        blk_ready = 1'b0;

        // illegal length: one-cycle err, no block
        send({hdr0, hdr1}, 16'd81, 1'b0);
        chk("bad_err", 512'(err), 512'(1));
        chk("bad_valid", 512'(blk_valid), 512'(0));
        chk("bad_ready", 512'(msg_ready), 512'(1));
        tick();
        chk("bad_err_clr", 512'(err), 512'(0));
        chk("bad_valid2", 512'(blk_valid), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
